// File: rtl/conv_layer_scheduler_pkg.sv
// Shared definitions for the convolution layer scheduler: default sizing
// and the scheduler state encoding.
package conv_layer_scheduler_pkg;

    localparam int DEF_NUM_KERNELS       = 2;
    localparam int DEF_NUM_OUT_ROWS      = 3;
    localparam int DEF_KERNEL_ADDR_WIDTH = 1;
    localparam int DEF_ROW_ADDR_WIDTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_ROW  = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_CONV = 3'd4,
        ST_WRITE     = 3'd5,
        ST_DONE      = 3'd6
    } sched_state_t;

    // True for every state that belongs to an in-flight layer.
    function automatic logic state_is_busy(input sched_state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/conv_index_counter.sv
// Nested kernel/row counter. The row index runs fastest; when it wraps the
// kernel index advances. On the very last (kernel,row) pair an advance holds
// the indices so the finished layer's last position stays visible.
module conv_index_counter
    import conv_layer_scheduler_pkg::*;
#(
    parameter int NUM_KERNELS       = DEF_NUM_KERNELS,
    parameter int NUM_OUT_ROWS      = DEF_NUM_OUT_ROWS,
    parameter int KERNEL_ADDR_WIDTH = DEF_KERNEL_ADDR_WIDTH,
    parameter int ROW_ADDR_WIDTH    = DEF_ROW_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         advance,
    output logic [KERNEL_ADDR_WIDTH-1:0] kernel,
    output logic [ROW_ADDR_WIDTH-1:0]    row,
    output logic                         kernel_last,
    output logic                         row_last
);

    assign kernel_last = (kernel == KERNEL_ADDR_WIDTH'(NUM_KERNELS - 1));
    assign row_last    = (row == ROW_ADDR_WIDTH'(NUM_OUT_ROWS - 1));

    // Index registers: clear at layer start, step after each written result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel <= '0;
            row    <= '0;
        end else if (clear) begin
            kernel <= '0;
            row    <= '0;
        end else if (advance) begin
            if (!row_last) begin
                row <= row + ROW_ADDR_WIDTH'(1);
            end else if (!kernel_last) begin
                row    <= '0;
                kernel <= kernel + KERNEL_ADDR_WIDTH'(1);
            end else begin
                row    <= row;
                kernel <= kernel;
            end
        end else begin
            kernel <= kernel;
            row    <= row;
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Layer scheduler: walks every (kernel,row) pair of a layer, loading weights
// once per kernel, refilling input rows per output row, kicking the
// convolution engine and handing each result to the output buffer.
// All control outputs are registered from the next state, so no input has a
// combinational path to an output.
module conv_layer_scheduler
    import conv_layer_scheduler_pkg::*;
#(
    parameter int NUM_KERNELS       = DEF_NUM_KERNELS,
    parameter int NUM_OUT_ROWS      = DEF_NUM_OUT_ROWS,
    parameter int KERNEL_ADDR_WIDTH = DEF_KERNEL_ADDR_WIDTH,
    parameter int ROW_ADDR_WIDTH    = DEF_ROW_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         layer_start,
    output logic                         layer_busy,
    output logic                         layer_done,
    output logic                         weight_load_req,
    input  logic                         weight_load_ack,
    output logic [KERNEL_ADDR_WIDTH-1:0] weight_sel,
    output logic                         row_load_req,
    input  logic                         row_load_ack,
    output logic [ROW_ADDR_WIDTH-1:0]    row_addr,
    output logic                         conv_start,
    input  logic                         conv_done,
    output logic                         result_valid,
    input  logic                         result_rdy
);

    sched_state_t state_r;
    sched_state_t state_next_s;
    logic         cnt_clear_s;
    logic         cnt_advance_s;
    logic         kernel_last_s;
    logic         row_last_s;

    conv_index_counter #(
        .NUM_KERNELS       (NUM_KERNELS),
        .NUM_OUT_ROWS      (NUM_OUT_ROWS),
        .KERNEL_ADDR_WIDTH (KERNEL_ADDR_WIDTH),
        .ROW_ADDR_WIDTH    (ROW_ADDR_WIDTH)
    ) u_index (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cnt_clear_s),
        .advance     (cnt_advance_s),
        .kernel      (weight_sel),
        .row         (row_addr),
        .kernel_last (kernel_last_s),
        .row_last    (row_last_s)
    );

    // Next-state logic; a handshake already high on entry advances at once.
    always_comb begin
        state_next_s  = state_r;
        cnt_clear_s   = 1'b0;
        cnt_advance_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (layer_start) begin
                    state_next_s = ST_LOAD_W;
                    cnt_clear_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                if (weight_load_ack) begin
                    state_next_s = ST_LOAD_ROW;
                end else begin
                    state_next_s = ST_LOAD_W;
                end
            end
            ST_LOAD_ROW: begin
                if (row_load_ack) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_LOAD_ROW;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT_CONV;
            end
            ST_WAIT_CONV: begin
                if (conv_done) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_WAIT_CONV;
                end
            end
            ST_WRITE: begin
                if (result_rdy) begin
                    cnt_advance_s = 1'b1;
                    if (!row_last_s) begin
                        state_next_s = ST_LOAD_ROW;
                    end else if (!kernel_last_s) begin
                        state_next_s = ST_LOAD_W;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and output registers decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            layer_busy      <= 1'b0;
            layer_done      <= 1'b0;
            weight_load_req <= 1'b0;
            row_load_req    <= 1'b0;
            conv_start      <= 1'b0;
            result_valid    <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            layer_busy      <= state_is_busy(state_next_s);
            layer_done      <= (state_next_s == ST_DONE);
            weight_load_req <= (state_next_s == ST_LOAD_W);
            row_load_req    <= (state_next_s == ST_LOAD_ROW);
            conv_start      <= (state_next_s == ST_START);
            result_valid    <= (state_next_s == ST_WRITE);
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: a job-list model (job j = kernel*ROWS+row,
// each job a short list of phases) predicts every output every cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_conv_layer_scheduler;

    localparam int NK = 2;
    localparam int NR = 3;
    localparam int NJ = NK * NR;
    // Phases a job walks through (PW only for the first row of a kernel).
    localparam int PW = 0;
    localparam int PR = 1;
    localparam int PS = 2;
    localparam int PC = 3;
    localparam int PX = 4;
    localparam int PD = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       layer_start = 1'b0;
    logic       weight_load_ack = 1'b0;
    logic       row_load_ack = 1'b0;
    logic       conv_done = 1'b0;
    logic       result_rdy = 1'b0;
    logic       layer_busy, layer_done, weight_load_req, row_load_req;
    logic       conv_start, result_valid;
    logic [0:0] weight_sel;
    logic [1:0] row_addr;

    int vectors = 0;
    int miscompares = 0;

    bit m_active = 1'b0;
    int m_p = PW;
    int m_j = 0;

    conv_layer_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .layer_start     (layer_start),
        .layer_busy      (layer_busy),
        .layer_done      (layer_done),
        .weight_load_req (weight_load_req),
        .weight_load_ack (weight_load_ack),
        .weight_sel      (weight_sel),
        .row_load_req    (row_load_req),
        .row_load_ack    (row_load_ack),
        .row_addr        (row_addr),
        .conv_start      (conv_start),
        .conv_done       (conv_done),
        .result_valid    (result_valid),
        .result_rdy      (result_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] expected_outputs();
        logic       ws;
        logic [1:0] ra;
        ws = 1'(m_j / NR);
        ra = 2'(m_j % NR);
        return {m_active, (m_active && m_p == PD), (m_active && m_p == PW), ws,
                (m_active && m_p == PR), ra, (m_active && m_p == PS),
                (m_active && m_p == PX)};
    endfunction

    function automatic logic [9:0] actual_outputs();
        return {layer_busy, layer_done, weight_load_req, weight_sel, row_load_req,
                row_addr, conv_start, result_valid};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_p = PW;
        m_j = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        if (!m_active) begin
            if (layer_start) begin
                m_active = 1'b1;
                m_p = PW;
                m_j = 0;
            end
        end else begin
            case (m_p)
                PW: if (weight_load_ack) m_p = PR;
                PR: if (row_load_ack) m_p = PS;
                PS: m_p = PC;
                PC: if (conv_done) m_p = PX;
                PX: begin
                    if (result_rdy) begin
                        if (m_j == NJ - 1) begin
                            m_p = PD;
                        end else begin
                            m_j = m_j + 1;
                            m_p = (m_j % NR == 0) ? PW : PR;
                        end
                    end
                end
                default: m_active = 1'b0;
            endcase
        end
    endtask

    task automatic compare();
        logic [9:0] a, e;
        a = actual_outputs();
        e = expected_outputs();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL outputs t=%0t got %b exp %b (busy,done,wreq,wsel,rreq,raddr,cstart,rvalid)",
                     $time, a, e);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        check_lit("reset_all_outputs_zero", int'(actual_outputs()), 0);
        #1;
        rst_n = 1'b1;
    endtask

    // One layer with every handshake high; noisy keeps layer_start high while
    // busy, and conv_done is constantly high (spurious outside WAIT_CONV).
    task automatic run_all_high(input bit noisy);
        int n, first_cs, n_cs, done_at;
        int ks[NJ];
        int rs[NJ];
        n = 0; first_cs = -1; n_cs = 0; done_at = -1;
        weight_load_ack = 1'b1; row_load_ack = 1'b1;
        conv_done = 1'b1; result_rdy = 1'b1;
        layer_start = 1'b1;
        while (done_at < 0 && n < 100) begin
            tick();
            n++;
            if (!noisy) layer_start = 1'b0;
            if (conv_start) begin
                if (first_cs < 0) first_cs = n;
                if (n_cs < NJ) begin
                    ks[n_cs] = int'(weight_sel);
                    rs[n_cs] = int'(row_addr);
                end
                n_cs++;
            end
            if (layer_done) done_at = n;
        end
        layer_start = 1'b0;
        check_lit("first_conv_start_latency", first_cs, 3);
        check_lit("conv_start_count", n_cs, 6);
        check_lit("cycles_to_layer_done", done_at, 27);
        for (int i = 0; i < NJ; i++) begin
            check_lit("order_kernel", ks[i], i / NR);
            check_lit("order_row", rs[i], i % NR);
        end
        tick();
        check_lit("idle_after_done_busy", int'(layer_busy), 0);
        check_lit("done_single_pulse", int'(layer_done), 0);
    endtask

    initial begin
        int n;
        #12;
        compare();
        check_lit("reset_state", int'(actual_outputs()), 0);
        rst_n = 1'b1;
        tick();

        // Plain layer, then the noisy version with repeated start / spurious done.
        run_all_high(1'b0);
        run_all_high(1'b1);

        // First WRITE stalled by result_rdy low for five cycles.
        weight_load_ack = 1'b1; row_load_ack = 1'b1; conv_done = 1'b1;
        result_rdy = 1'b0; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin tick(); n++; end
        check_lit("write_reached", int'(result_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check_lit("stall_valid", int'(result_valid), 1);
            check_lit("stall_sel_addr", int'({weight_sel, row_addr}), 0);
            check_lit("stall_no_conv_start", int'(conv_start), 0);
            tick();
        end
        result_rdy = 1'b1;
        n = 0;
        while (!layer_done && n < 60) begin tick(); n++; end
        check_lit("stall_layer_done", int'(layer_done), 1);
        tick();

        // Weight load ack delayed: four request cycles, then row request.
        weight_load_ack = 1'b0; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_lit("wreq_held", int'({weight_load_req, row_load_req}), 2);
            if (i < 3) tick();
        end
        weight_load_ack = 1'b1;
        tick();
        check_lit("rreq_after_wack", int'({weight_load_req, row_load_req}), 1);
        n = 0;
        while (!layer_done && n < 60) begin tick(); n++; end
        tick();

        // Reset while waiting on the convolution of (1,1).
        conv_done = 1'b1; layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        n = 0;
        while (!(conv_start && weight_sel == 1'b1 && row_addr == 2'd1) && n < 60) begin
            tick(); n++;
        end
        conv_done = 1'b0;
        tick();
        tick();
        check_lit("held_in_wait_conv_busy", int'(layer_busy), 1);
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_lit("no_done_after_abort", int'(layer_done), 0);
        end
        run_all_high(1'b0);

        // Randomized traffic against the model, with rare mid-layer resets.
        for (int c = 0; c < 3000; c++) begin
            layer_start     = ($urandom_range(0, 7) == 0);
            weight_load_ack = ($urandom_range(0, 2) != 0);
            row_load_ack    = ($urandom_range(0, 2) != 0);
            conv_done       = ($urandom_range(0, 3) == 0);
            result_rdy      = ($urandom_range(0, 2) != 0);
            tick();
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
